xor_descrambler_4bits: RTL and testbench
========================================

# xor_descrambler_4bits

Receive-side counterpart of the 4-bit XOR scrambling path: recovers plain nibbles by XOR-ing each incoming 4-bit word with a frame-synchronous LFSR keystream. It sits between the link input and the payload consumer, with valid/ready handshakes on both sides. A frame state machine reseeds the keystream at each start of frame and counts nibbles to find the end of frame. Protocol violations are flagged.

## Interface
- `FRAME_NIBBLES`, default 16: nibbles per frame; legal range is 2..256.
- `DEFAULT_SEED`, default 7'h7F: seed used when `seed_i` is zero.
- `clk_i` in 1: single clock; all logic is rising-edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `seed_i` in 7: LFSR seed, sampled on the accepted start-of-frame beat.
- `data_i` in 4: scrambled nibble.
- `sof_i` in 1: marks the first nibble of a frame; qualified by `valid_i`.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: input beat accepted when `valid_i & ready_o`.
- `data_o` out 4: descrambled nibble.
- `sof_o` out 1: first nibble of the frame.
- `eof_o` out 1: last nibble of the frame.
- `valid_o` out 1: output beat valid.
- `ready_i` in 1: downstream ready.
- `err_o` out 1: one-cycle pulse on a protocol violation.

## Operation
- **Keystream**: 7-bit LFSR `s`, polynomial x^7+x^6+1.
  - One step computes `k = s[6]^s[5]`, then `s <= {s[5:0],k}`.
  - Four steps are taken per accepted nibble.
  - The first key bit applies to `data[3]` and the fourth to `data[0]`.
- **States**: IDLE, RUN.
- **IDLE**:
  - Accepted beat with `sof_i=1`:
    - Load the seed (`seed_i`, or `DEFAULT_SEED` if `seed_i==0`).
    - Descramble this nibble with the first 4 key bits of the new seed.
    - Set the count to 1 and go to RUN.
  - Accepted beat with `sof_i=0`: drop the beat (no output) and pulse `err_o`. Stay in IDLE.
- **RUN**:
  - Accepted beat with `sof_i=0`: descramble, advance the LFSR and increment the count.
  - When the count reaches `FRAME_NIBBLES`, drive `eof_o=1` on that output beat and return to IDLE.
  - Accepted beat with `sof_i=1` (early resync):
    - Pulse `err_o`.
    - Reseed and treat the beat exactly as an IDLE start of frame; the count restarts at 1.
    - The unfinished frame is never given `eof_o`.
- Width rules:
  - Nibble count width is `$clog2(FRAME_NIBBLES+1)`.
  - The LFSR never holds zero, because a zero seed is substituted.
- With `FRAME_NIBBLES=1`-style degenerate framing excluded, `sof_o` and `eof_o` are never both set.

## Timing
- Reset values: `valid_o=0`, `data_o=0`, `sof_o=0`, `eof_o=0`, `err_o=0`, `ready_o=0`, state IDLE, LFSR = `DEFAULT_SEED`, count 0.
- One output register stage:
  - `ready_o = !rst_i & (!valid_o | ready_i)`.
  - Latency is 1 cycle from accepted input to `valid_o`.
  - Full throughput of 1 nibble per cycle when `ready_i=1`.
- While `valid_o=1 & ready_i=0`, all outputs hold stable and nothing is accepted.
- `err_o` asserts the cycle after the offending beat is accepted and lasts exactly 1 cycle, independent of `ready_i`.
- Dropped IDLE beats never raise `valid_o`.
- Reset mid-frame: the next cycle shows reset values and any pending output beat is discarded.

## Structure
- Package `xor_scr_pkg` holds:
  - `LFSR_W=7`, the tap positions and `DEFAULT_SEED`.
  - The `state_t` enum {IDLE, RUN}.
  - A function `keystream4(s)` returning {next_state, key[3:0]}.
- Sub-module: instantiate the existing `xor_4bits` for `data_i ^ key`.
- Top file: FSM, count, LFSR register, output register.

## Test plan
- **Seed 7'h7F, `sof`+4'hA then 4'hA, `ready_i=1`**: outputs 4'hA (`sof_o=1`) then 4'h8, each 1 cycle after acceptance. Keystream is 4'h0 then 4'h2.
- **Seed 0 versus seed 7'h7F on identical frames**: identical outputs (substitution works).
- **Full frame of 16 nibbles, then `sof` again**: `eof_o` only on the 16th output; the next frame restarts the keystream at 4'h0.
- **Beat with `sof_i=0` after reset**: no `valid_o` and a 1-cycle `err_o`. **`sof` at nibble 5**: `err_o` pulses, keystream restarts, and no `eof_o` is given to the old frame.
- **`ready_i` toggling 1-0-0-1 during a frame**: data held while stalled, `ready_o` low while the output is full, no loss or duplication.
- **`rst_i` asserted for 1 cycle mid-frame with `valid_o=1`**: all outputs 0 the next cycle; subsequent non-`sof` beats are dropped with `err_o`.

Source files
------------

// File: rtl/xor_scr_pkg.sv
// rtl/xor_scr_pkg.sv - shared types, constants and keystream helper for the 4-bit descrambler
package xor_scr_pkg;

  localparam int LFSR_W = 7;

  // Feedback taps for x^7 + x^6 + 1 (bit indices into the shift register)
  localparam int TAP_HI = 6;
  localparam int TAP_LO = 5;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // {register value after four steps, four key bits with the first step in key[3]}
  typedef struct packed {
    logic [LFSR_W-1:0] next_state;
    logic [3:0]        key;
  } ks_t;

  // Advance the LFSR four steps and collect the generated key bits MSB-first
  function automatic ks_t keystream4(input logic [LFSR_W-1:0] s);
    ks_t               r;
    logic [LFSR_W-1:0] t;
    logic              fb;
    t     = s;
    r.key = '0;
    for (int i = 0; i < 4; i++) begin
      fb         = t[TAP_HI] ^ t[TAP_LO];
      t          = {t[LFSR_W-2:0], fb};
      r.key[3-i] = fb;
    end
    r.next_state = t;
    return r;
  endfunction

endpackage

// File: rtl/xor_4bits.sv
// rtl/xor_4bits.sv - bitwise XOR of two nibbles
module xor_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_descrambler_4bits.sv
// rtl/xor_descrambler_4bits.sv - frame-synchronous LFSR descrambler with one output register stage
module xor_descrambler_4bits #(
  parameter int         FRAME_NIBBLES = 16,
  parameter logic [6:0] DEFAULT_SEED  = xor_scr_pkg::DEFAULT_SEED
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] seed_i,
  input  logic [3:0] data_i,
  input  logic       sof_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [3:0] data_o,
  output logic       sof_o,
  output logic       eof_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       err_o
);

  import xor_scr_pkg::*;

  localparam int               CNT_W    = $clog2(FRAME_NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_NIBBLES);

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic [LFSR_W-1:0]   seed_eff;
  logic [LFSR_W-1:0]   ks_src;
  ks_t                 ks;
  logic [3:0]          plain;
  logic [CNT_W-1:0]    cnt_inc;

  logic                load;
  logic                sof_d;
  logic                eof_d;
  logic                err_d;

  // The slot is free when empty or when its beat leaves this cycle; never during reset
  assign ready_o = !rst_i && (!valid_o || ready_i);
  assign accept  = valid_i && ready_o;

  // A zero seed would lock the LFSR at zero, so it is replaced
  assign seed_eff = (seed_i == '0) ? DEFAULT_SEED : seed_i;

  // A start-of-frame beat is keyed from the fresh seed, all others from the running register
  assign ks_src  = sof_i ? seed_eff : lfsr_q;
  assign ks      = keystream4(ks_src);
  assign cnt_inc = cnt_q + CNT_W'(1);

  xor_4bits u_xor (
    .a (data_i),
    .b (ks.key),
    .y (plain)
  );

  // Frame tracking: next state, keystream advance, nibble count and error detection
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    if (accept) begin
      if (sof_i) begin
        // Fresh frame; a start seen mid-frame abandons the old frame without an eof
        err_d   = (state_q == RUN);
        lfsr_d  = ks.next_state;
        cnt_d   = CNT_W'(1);
        load    = 1'b1;
        sof_d   = 1'b1;
        state_d = RUN;
      end else if (state_q == RUN) begin
        lfsr_d = ks.next_state;
        load   = 1'b1;
        if (cnt_inc == LAST_CNT) begin
          eof_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        // Payload outside a frame is discarded
        err_d = 1'b1;
      end
    end
  end

  // Frame state, keystream register and nibble counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      lfsr_q  <= DEFAULT_SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stage: load on an accepted beat, empty once downstream takes it, hold while stalled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sof_o   <= 1'b0;
      eof_o   <= 1'b0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= plain;
      sof_o   <= sof_d;
      eof_o   <= eof_d;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Protocol error pulse, one cycle after the offending beat regardless of downstream
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= err_d;
    end
  end

endmodule

// File: tb/tb_xor_descrambler_4bits.sv
// tb/tb_xor_descrambler_4bits.sv - scoreboard bench for the 4-bit descrambler
module tb_xor_descrambler_4bits;

  localparam int FN = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] seed_i = '0;
  logic [3:0] data_i = '0;
  logic       sof_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [3:0] data_o;
  logic       sof_o;
  logic       eof_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       err_o;

  always #5 clk = ~clk;

  xor_descrambler_4bits #(.FRAME_NIBBLES(FN), .DEFAULT_SEED(7'h7F)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .seed_i  (seed_i),
    .data_i  (data_i),
    .sof_i   (sof_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .sof_o   (sof_o),
    .eof_o   (eof_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  typedef struct {
    logic [3:0] d;
    logic       s;
    logic       e;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [3:0] d;
    logic       s;
    logic       e;
  } obs_t;

  exp_t out_q[$];
  int   err_q[$];
  obs_t obs[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit seen = 0;
  bit rdy_rand = 0;

  bit m_in_frame = 0;
  int m_pos = 0;
  int m_keys[FN];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Keystream of a whole frame: each nibble is four successive feedback bits, first bit in the MSB
  function automatic void build_keys(input logic [6:0] sd);
    int st;
    int fb;
    int k;
    st = (sd == 0) ? 127 : int'(sd);
    for (int i = 0; i < FN; i++) begin
      k = 0;
      for (int b = 0; b < 4; b++) begin
        fb = ((st >> 6) ^ (st >> 5)) & 1;
        st = ((st << 1) | fb) & 127;
        k  = (k << 1) | fb;
      end
      m_keys[i] = k;
    end
  endfunction

  task automatic model_accept(input bit s, input logic [3:0] d, input logic [6:0] sd, input int c);
    exp_t e;
    if (s) begin
      if (m_in_frame) err_q.push_back(c + 1);
      build_keys(sd);
      e.d = d ^ 4'(m_keys[0]);
      e.s = 1'b1;
      e.e = 1'b0;
      e.cyc = c + 1;
      out_q.push_back(e);
      m_pos = 1;
      m_in_frame = 1;
    end else if (m_in_frame) begin
      e.d = d ^ 4'(m_keys[m_pos]);
      e.s = 1'b0;
      e.e = (m_pos == FN - 1);
      e.cyc = c + 1;
      out_q.push_back(e);
      m_pos++;
      if (e.e) m_in_frame = 0;
    end else begin
      err_q.push_back(c + 1);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard queues
  always @(negedge clk) begin
    bit e_exp;
    obs_t o;
    if (rst_i) begin
      out_q.delete();
      err_q.delete();
      seen = 0;
    end else begin
      e_exp = (err_q.size() > 0) && (err_q[0] == cyc);
      check("err_o", err_o, e_exp);
      if (e_exp) void'(err_q.pop_front());
      check("ready_o", ready_o, !valid_o || ready_i);
      if (valid_o) begin
        if (out_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got valid_o=1 data %0h expected no beat (cycle %0d)", data_o, cyc);
        end else begin
          check("data_o", data_o, out_q[0].d);
          check("sof_o", sof_o, out_q[0].s);
          check("eof_o", eof_o, out_q[0].e);
          if (!seen) begin
            check("latency_cycle", cyc, out_q[0].cyc);
            seen = 1;
          end
          if (ready_i) begin
            o.d = data_o;
            o.s = sof_o;
            o.e = eof_o;
            obs.push_back(o);
            void'(out_q.pop_front());
            seen = 0;
          end
        end
      end else if (out_q.size() > 0 && out_q[0].cyc <= cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_beat: got valid_o=0 expected data %0h (cycle %0d)", out_q[0].d, cyc);
        void'(out_q.pop_front());
        seen = 0;
      end
    end
  end

  function automatic bit pick_ready();
    if (rdy_rand) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  task automatic cyc_drive(input bit v, input bit s, input logic [3:0] d, input logic [6:0] sd,
                           input bit r, output bit acc);
    @(posedge clk);
    #2;
    valid_i = v;
    sof_i   = s;
    data_i  = d;
    seed_i  = sd;
    ready_i = r;
    @(negedge clk);
    acc = valid_i && ready_o;
    if (acc) model_accept(s, d, sd, cyc);
  endtask

  task automatic send(input bit s, input logic [3:0] d, input logic [6:0] sd);
    bit acc;
    int n;
    n = 0;
    do begin
      cyc_drive(1'b1, s, d, sd, pick_ready(), acc);
      n++;
    end while (!acc && n < 64);
    check("beat_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'b0, 4'($urandom), 7'($urandom), pick_ready(), acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((out_q.size() != 0 || err_q.size() != 0) && n < 200) begin
      cyc_drive(1'b0, 1'b0, 4'h0, 7'h0, 1'b1, acc);
      n++;
    end
    cyc_drive(1'b0, 1'b0, 4'h0, 7'h0, 1'b1, acc);
    check("drained", out_q.size() + err_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_data_o", data_o, 4'h0);
    check("rst_sof_o", sof_o, 1'b0);
    check("rst_eof_o", eof_o, 1'b0);
    check("rst_err_o", err_o, 1'b0);
    check("rst_ready_o", ready_o, 1'b0);
    m_in_frame = 0;
    m_pos = 0;
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] fd[FN];
    logic [3:0] first_run[FN];
    logic [3:0] tog_d[6];
    bit         pat[4];
    bit         acc;
    int         k;
    int         t;

    do_reset();

    // Reference vector: seed 7F, A then A -> A then 8
    rdy_rand = 0;
    obs.delete();
    send(1'b1, 4'hA, 7'h7F);
    send(1'b0, 4'hA, 7'h00);
    drain();
    check("vec_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      check("vec0_data", obs[0].d, 4'hA);
      check("vec0_sof", obs[0].s, 1'b1);
      check("vec1_data", obs[1].d, 4'h8);
    end

    // Zero seed substitution on two identical full frames, then restart after eof
    do_reset();
    for (int i = 0; i < FN; i++) fd[i] = 4'($urandom);
    obs.delete();
    for (int i = 0; i < FN; i++) send(i == 0, fd[i], 7'h00);
    drain();
    check("seed0_count", obs.size(), FN);
    for (int i = 0; i < FN && i < obs.size(); i++) first_run[i] = obs[i].d;
    obs.delete();
    for (int i = 0; i < FN; i++) send(i == 0, fd[i], 7'h7F);
    send(1'b1, 4'hA, 7'h7F);
    drain();
    check("seed7f_count", obs.size(), FN + 1);
    if (obs.size() == FN + 1) begin
      for (int i = 0; i < FN; i++) check("seed_subst_data", obs[i].d, first_run[i]);
      check("frame_eof_last", obs[FN-1].e, 1'b1);
      check("restart_data", obs[FN].d, 4'hA);
    end

    // Payload beat with no frame open, then early resync at nibble 5
    do_reset();
    obs.delete();
    send(1'b0, 4'h5, 7'h00);
    idle(3);
    drain();
    check("dropped_no_output", obs.size(), 0);
    send(1'b1, 4'h3, 7'h21);
    for (int i = 1; i < 4; i++) send(1'b0, 4'($urandom), 7'h00);
    send(1'b1, 4'h6, 7'h15);
    for (int i = 1; i < FN; i++) send(1'b0, 4'($urandom), 7'h00);
    drain();

    // Downstream ready toggling 1-0-0-1 during a frame
    do_reset();
    obs.delete();
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 6; i++) tog_d[i] = 4'($urandom);
    k = 0;
    t = 0;
    while (k < 6 && t < 40) begin
      cyc_drive(1'b1, k == 0, tog_d[k], 7'h2A, pat[t % 4], acc);
      if (acc) k++;
      t++;
    end
    check("toggle_all_sent", k, 6);
    drain();
    check("toggle_count", obs.size(), 6);

    // Reset while an output beat is held, then payload without a frame
    do_reset();
    send(1'b1, 4'h1, 7'h40);
    send(1'b0, 4'h2, 7'h00);
    cyc_drive(1'b0, 1'b0, 4'h0, 7'h0, 1'b0, acc);
    check("held_valid_o", valid_o, 1'b1);
    do_reset();
    obs.delete();
    send(1'b0, 4'h9, 7'h00);
    send(1'b0, 4'hC, 7'h00);
    drain();
    check("post_reset_no_output", obs.size(), 0);

    // Randomized traffic with random back-pressure and occasional resyncs
    do_reset();
    rdy_rand = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) idle(1);
      send((i == 0) || ($urandom_range(0, 19) == 0), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom));
    end
    rdy_rand = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
